// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises and filters kbclk/in and
// emits validated bytes. Define PS2_RX_TIMEOUT_EN to add the in-frame watchdog.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] kb_sync;
  logic [SYNC_STAGES-1:0] in_sync;
  logic                   kb_s;
  logic                   in_s;
  logic [FCW-1:0]         filt_cnt;
  logic                   fclk;
  logic                   fall;
  logic [FILT_LEN-1:0]    in_dly;
  logic                   bit_in;
  logic [1:0]             state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   parity;

  assign kb_s   = kb_sync[SYNC_STAGES-1];
  assign in_s   = in_sync[SYNC_STAGES-1];
  assign bit_in = in_dly[FILT_LEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_sync <= '1;
      in_sync <= '1;
    end else begin
      kb_sync <= {kb_sync[SYNC_STAGES-2:0], kbclk};
      in_sync <= {in_sync[SYNC_STAGES-2:0], in};
    end
  end

  // Data is delayed by FILT_LEN so the sampled bit lines up with the first
  // low kbclk sample that the filter eventually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      in_dly   <= '1;
    end else begin
      fall      <= 1'b0;
      in_dly[0] <= in_s;
      for (int i = 1; i < FILT_LEN; i++) in_dly[i] <= in_dly[i-1];
      if (kb_s == fclk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        fclk     <= kb_s;
        filt_cnt <= '0;
        fall     <= ~kb_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      data    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      wd_cnt  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (fall) begin
`ifdef PS2_RX_TIMEOUT_EN
        // Starts at 1 because the fall-event cycle itself already elapsed.
        wd_cnt <= WDW'(1);
`endif
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity <= bit_in;
            state  <= STOP;
          end
          default: begin
            if (bit_in && (^shreg ^ parity)) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      else if (state != IDLE) begin
        if (wd_cnt == WD_LAST) begin
          err    <= 1'b1;
          state  <= IDLE;
          busy   <= 1'b0;
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are driven bit by bit, expected bytes are
// queued at issue time and a negedge monitor checks every valid/err pulse.
module tb_ps2_rx;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 50000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kbclk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t push_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_fall = 0;

  ps2_rx #(
    .SYNC_STAGES(2),
    .FILT_LEN(4),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kbclk(kbclk),
    .in(ps2_data),
    .data(data),
    .valid(valid),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expectFrame(input bit is_err, input logic [7:0] d);
    push_e.is_err = is_err;
    push_e.d      = d;
    exp_q.push_back(push_e);
  endtask

  // Drives the first nbits bits of a frame; glitch_after inserts a 2-cycle
  // kbclk low pulse during the high phase following that bit index.
  task automatic applyStimulus(input logic [7:0] b, input bit par, input bit stp,
                               input int nbits, input int glitch_after);
    logic [10:0] f;
    int got;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (10) @(posedge clk);
      #1 kbclk = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        got = -1;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk);
          #1;
          if ((valid || err) && got < 0) got = cyc - last_fall;
        end
        checkOutput("stop_to_strobe_latency", got, 7);
      end else begin
        repeat (20) @(posedge clk);
        #1;
      end
      checkOutput($sformatf("busy_bit%0d", i), {31'd0, busy}, {31'd0, (i < 10)});
      @(posedge clk);
      #1 kbclk = 1'b1;
      if (i == glitch_after) begin
        repeat (5) @(posedge clk);
        #1 kbclk = 1'b0;
        repeat (2) @(posedge clk);
        #1 kbclk = 1'b1;
      end
      repeat (10) @(posedge clk);
    end
    ps2_data = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid || err)) begin
      checkOutput("valid_err_exclusive", {31'd0, valid & err}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe_queue_size", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("strobe_is_err", {31'd0, err}, {31'd0, mon_e.is_err});
        checkOutput("strobe_data", {24'd0, data}, {24'd0, mon_e.d});
      end
    end
  end

  initial begin
    int got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data", {24'd0, data}, 32'h00);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    expectFrame(1'b0, 8'h1C);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1);

    expectFrame(1'b1, 8'h1C);
    applyStimulus(8'h1C, 1'b1, 1'b1, 11, -1);

    expectFrame(1'b1, 8'h1C);
    applyStimulus(8'hF0, 1'b1, 1'b0, 11, -1);

    expectFrame(1'b0, 8'h12);
    applyStimulus(8'h12, 1'b1, 1'b1, 11, -1);

    @(posedge clk);
    #1 kbclk = 1'b0;
    repeat (2) @(posedge clk);
    #1 kbclk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_glitch_busy", {31'd0, busy}, 32'd0);

    expectFrame(1'b0, 8'h5A);
    applyStimulus(8'h5A, 1'b1, 1'b1, 11, 3);

    applyStimulus(8'h33, 1'b0, 1'b1, 5, -1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midframe_reset_data", {24'd0, data}, 32'h00);
    checkOutput("midframe_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midframe_reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("midframe_reset_err", {31'd0, err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    expectFrame(1'b0, 8'h29);
    applyStimulus(8'h29, 1'b0, 1'b1, 11, -1);

`ifdef PS2_RX_TIMEOUT_EN
    expectFrame(1'b1, 8'h29);
    applyStimulus(8'hAB, 1'b1, 1'b1, 6, -1);
    got = -1;
    for (int k = 0; k < 300 && got < 0; k++) begin
      @(posedge clk);
      #1;
      if (err) got = cyc - last_fall;
    end
    checkOutput("timeout_latency", got, 106);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(posedge clk);
    expectFrame(1'b0, 8'hE0);
    applyStimulus(8'hE0, 1'b0, 1'b1, 11, -1);
`else
    got = 0;
`endif

    repeat (20) @(posedge clk);
    #1;
    checkOutput("final_data", {24'd0, data},
`ifdef PS2_RX_TIMEOUT_EN
                32'hE0
`else
                32'h29
`endif
                );
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
